driver_motor_pwm: RTL and testbench
===================================

# driver_motor_pwm

- Back end of the motor path. Takes the per-driver direction codes and 12-bit duty compare values produced by the movement logic, and turns them into H-bridge pins: IN1/IN2 direction and an EN PWM line for each of drivers A and B.
- Provides:
  - a free-running PWM period counter;
  - period-synchronous (shadow) updates of direction and duty;
  - a dead-time coast interval on every forward/reverse reversal;
  - an optional soft-start duty ramp.

## Interface
Parameters:
- PERIOADA, 1000: PWM period in clk cycles; counter runs 0..PERIOADA-1.
- TIMP_MORT, 50: coast cycles inserted on a 10↔01 reversal.
- PAS_RAMPA, 16: soft-start duty increment per period.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- directie_driverA  in  2  direction code for A: 10 forward, 01 reverse, 00 brake, 11 coast.
- directie_driverB  in  2  direction code for B, same encoding.
- factor_dc_driverA  in  12  duty compare value for A.
- factor_dc_driverB  in  12  duty compare value for B.
- in1_A, in2_A, en_A  out  1 each  H-bridge pins, driver A.
- in1_B, in2_B, en_B  out  1 each  H-bridge pins, driver B.
- sfarsit_perioada  out  1  one-cycle pulse on the last cycle of each period.
- timp_mort_A, timp_mort_B  out  1 each  high while that channel is in dead-time.

## Operation
Period counter:
- 12-bit, increments every cycle and wraps PERIOADA-1 → 0.
- sfarsit_perioada is high during the counter==PERIOADA-1 cycle.

Shadow update:
- On the counter==PERIOADA-1 cycle, each channel's directie/factor_dc inputs load into shadow registers.
- Changes between period ends are ignored; the new values take effect from the next period start.

Duty:
- Active duty = shadow value, or the ramp value when ramping.
- Duty ≥ PERIOADA means EN is high for the whole period.
- Duty 0 means EN is always low.
- en_X = (counter < active duty), unsigned 12-bit compare.

Per-channel FSM, states MERS and TIMP_MORT:
- MERS, pin mapping by applied direction:
  - 10: IN1=1, IN2=0, EN=PWM.
  - 01: IN1=0, IN2=1, EN=PWM.
  - 00 (brake): IN1=0, IN2=0, EN=1.
  - 11 (coast): IN1=0, IN2=0, EN=0.
- MERS → TIMP_MORT when a shadow load turns the applied direction from 10 to 01 or 01 to 10.
  - TIMP_MORT outputs IN1=IN2=EN=0, timp_mort_X=1.
  - A down-counter loads TIMP_MORT.
- TIMP_MORT → MERS when the down-counter reaches 0. The channel applies the shadow direction current at that moment.
- Shadow loads during TIMP_MORT update the shadow only. They neither restart nor extend the dead-time.
- All transitions involving 00 or 11 apply with no dead-time.
- Channels A and B are fully independent.

Reset (asynchronous, takes effect immediately, including mid-period or mid-dead-time):
- counter = 0.
- Shadow direction = 11, shadow duty = 0.
- FSM = MERS, ramp = 0.
- All outputs = 0.

## Timing
- All outputs are registered.
- Pin outputs in cycle n+1 reflect the counter, state and shadow of cycle n.
- First shadow load after reset: cycle PERIOADA-1 after rst_n deasserts. Pins reflect it from cycle PERIOADA+1.
- Dead-time holds all three pins low for exactly TIMP_MORT cycles. The new direction appears on the following cycle.
- Duty change latency: takes effect at the next period boundary, plus 1 cycle of output register.

## Configuration
Macro RAMPA_SOFT_EN:
- Defined:
  - Per channel, the ramp register resets to 0 on reset, on leaving TIMP_MORT, and on a shadow load that changes direction from 00/11 to 10/01.
  - At each period end: ramp = min(ramp+PAS_RAMPA, shadow duty), saturating.
  - Active duty = ramp.
  - A shadow duty below the current ramp clamps the ramp down immediately.
- Not defined: the ramp logic is absent and active duty = shadow duty.

## Test plan
Bench parameters: PERIOADA=10, TIMP_MORT=3, PAS_RAMPA=4.
- Reset, then hold dirA=10, dcA=6, without RAMPA_SOFT_EN → from the second period, in1_A=1, in2_A=0, en_A high 6 of every 10 cycles. sfarsit_perioada pulses every 10 cycles.
- dcA=12'h998 (≥PERIOADA) → en_A constantly 1. dcA=0 → en_A constantly 0.
- dirA 10→01 applied at a period end → exactly 3 cycles of in1_A=in2_A=en_A=0 with timp_mort_A=1, then in2_A=1 and PWM resumes. Channel B is unaffected.
- dirA 10→00 → brake pins (0,0,1) on the next boundary+1 with no dead-time. Toggle inputs mid-period → no output change until the boundary.
- With RAMPA_SOFT_EN, dirA=10, dcA=9 from coast → en_A high 4, 8, 9, 9… cycles in successive periods.
- Assert rst_n low mid-dead-time → all outputs 0 immediately. After release, outputs stay 0 until the first shadow load.

Source files
------------

// File: rtl/driver_motor_pwm.sv
// rtl/driver_motor_pwm.sv - H-bridge direction/PWM back end for motor drivers A and B
// Optional soft-start duty ramp enabled by defining RAMPA_SOFT_EN.

module driver_motor_pwm_canal #(
  parameter int TIMP_MORT = 50
`ifdef RAMPA_SOFT_EN
  ,
  parameter int PAS_RAMPA = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] contor_i,
  input  logic        sfarsit_i,
  input  logic [1:0]  directie_i,
  input  logic [11:0] factor_dc_i,
  output logic        in1_o,
  output logic        in2_o,
  output logic        en_o,
  output logic        timp_mort_o
);

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_FRANA = 2'b00;
  localparam logic [1:0] DIR_LIBER = 2'b11;

  localparam int CW = (TIMP_MORT > 2) ? $clog2(TIMP_MORT) : 1;
  localparam logic [CW-1:0] MORT_INIT = (TIMP_MORT > 0) ? CW'(TIMP_MORT - 1) : '0;

  typedef enum logic { S_MERS, S_TIMP_MORT } stare_t;

  stare_t        stare_q;
  logic [1:0]    dir_q;
  logic [11:0]   duty_q;
  logic [CW-1:0] mort_q;
  logic          in1_q, in2_q, en_q, timp_mort_q;

  logic          inversare_d;
  logic          iesire_mort_d;
  logic [11:0]   duty_activ_d;
  logic          pwm_d;

  // Only a direct forward<->reverse swap of the applied direction needs a coast gap
  assign inversare_d = sfarsit_i && (TIMP_MORT > 0) && (stare_q == S_MERS) &&
                       (((dir_q == DIR_FWD) && (directie_i == DIR_REV)) ||
                        ((dir_q == DIR_REV) && (directie_i == DIR_FWD)));
  assign iesire_mort_d = (stare_q == S_TIMP_MORT) && (mort_q == '0);

`ifdef RAMPA_SOFT_EN
  logic [11:0] rampa_q;
  logic [11:0] rampa_d;
  logic [11:0] rampa_baza;
  logic [12:0] rampa_suma;
  logic        pornire;

  always_comb begin
    pornire    = ((dir_q == DIR_FRANA) || (dir_q == DIR_LIBER)) &&
                 ((directie_i == DIR_FWD) || (directie_i == DIR_REV));
    rampa_baza = pornire ? 12'd0 : rampa_q;
    rampa_suma = {1'b0, rampa_baza} + 13'(PAS_RAMPA);
    rampa_d    = rampa_q;
    if (iesire_mort_d) begin
      rampa_d = '0;
    end else if (sfarsit_i) begin
      rampa_d = (rampa_suma > {1'b0, factor_dc_i}) ? factor_dc_i : rampa_suma[11:0];
    end
  end

  assign duty_activ_d = rampa_q;
`else
  assign duty_activ_d = duty_q;
`endif

  assign pwm_d = (contor_i < duty_activ_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stare_q     <= S_MERS;
      dir_q       <= DIR_LIBER;
      duty_q      <= '0;
      mort_q      <= '0;
      in1_q       <= 1'b0;
      in2_q       <= 1'b0;
      en_q        <= 1'b0;
      timp_mort_q <= 1'b0;
`ifdef RAMPA_SOFT_EN
      rampa_q     <= '0;
`endif
    end else begin
      if (sfarsit_i) begin
        dir_q  <= directie_i;
        duty_q <= factor_dc_i;
      end
`ifdef RAMPA_SOFT_EN
      rampa_q <= rampa_d;
`endif
      case (stare_q)
        S_MERS: begin
          if (inversare_d) begin
            stare_q <= S_TIMP_MORT;
            mort_q  <= MORT_INIT;
          end
        end
        S_TIMP_MORT: begin
          if (iesire_mort_d) begin
            stare_q <= S_MERS;
          end else begin
            mort_q <= mort_q - CW'(1);
          end
        end
      endcase

      timp_mort_q <= (stare_q == S_TIMP_MORT);
      if (stare_q == S_TIMP_MORT) begin
        {in1_q, in2_q, en_q} <= 3'b000;
      end else begin
        case (dir_q)
          DIR_FWD:   {in1_q, in2_q, en_q} <= {2'b10, pwm_d};
          DIR_REV:   {in1_q, in2_q, en_q} <= {2'b01, pwm_d};
          DIR_FRANA: {in1_q, in2_q, en_q} <= 3'b001;
          default:   {in1_q, in2_q, en_q} <= 3'b000;
        endcase
      end
    end
  end

  assign in1_o       = in1_q;
  assign in2_o       = in2_q;
  assign en_o        = en_q;
  assign timp_mort_o = timp_mort_q;

endmodule

module driver_motor_pwm #(
  parameter int PERIOADA  = 1000,
  parameter int TIMP_MORT = 50,
  parameter int PAS_RAMPA = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic        in1_A,
  output logic        in2_A,
  output logic        en_A,
  output logic        in1_B,
  output logic        in2_B,
  output logic        en_B,
  output logic        sfarsit_perioada,
  output logic        timp_mort_A,
  output logic        timp_mort_B
);

  if (PERIOADA < 2 || PERIOADA > 4096 || PAS_RAMPA < 0) begin : g_param_invalid
    $error("driver_motor_pwm: PERIOADA must be 2..4096 and PAS_RAMPA non-negative");
  end

  localparam logic [11:0] ULTIM = 12'(PERIOADA - 1);

  logic [11:0] contor_q;
  logic [11:0] contor_d;
  logic        sfarsit_q;
  logic        ultim_d;

  assign ultim_d  = (contor_q == ULTIM);
  assign contor_d = ultim_d ? 12'd0 : contor_q + 12'd1;

  // Registered from the next count so the pulse lines up with the counter's last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contor_q  <= '0;
      sfarsit_q <= 1'b0;
    end else begin
      contor_q  <= contor_d;
      sfarsit_q <= (contor_d == ULTIM);
    end
  end

  assign sfarsit_perioada = sfarsit_q;

  driver_motor_pwm_canal #(
    .TIMP_MORT(TIMP_MORT)
`ifdef RAMPA_SOFT_EN
    ,
    .PAS_RAMPA(PAS_RAMPA)
`endif
  ) u_canal_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .contor_i    (contor_q),
    .sfarsit_i   (ultim_d),
    .directie_i  (directie_driverA),
    .factor_dc_i (factor_dc_driverA),
    .in1_o       (in1_A),
    .in2_o       (in2_A),
    .en_o        (en_A),
    .timp_mort_o (timp_mort_A)
  );

  driver_motor_pwm_canal #(
    .TIMP_MORT(TIMP_MORT)
`ifdef RAMPA_SOFT_EN
    ,
    .PAS_RAMPA(PAS_RAMPA)
`endif
  ) u_canal_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .contor_i    (contor_q),
    .sfarsit_i   (ultim_d),
    .directie_i  (directie_driverB),
    .factor_dc_i (factor_dc_driverB),
    .in1_o       (in1_B),
    .in2_o       (in2_B),
    .en_o        (en_B),
    .timp_mort_o (timp_mort_B)
  );

endmodule

// File: tb/tb_driver_motor_pwm.sv
// tb/tb_driver_motor_pwm.sv - scoreboard bench for driver_motor_pwm (PERIOADA=10, TIMP_MORT=3, PAS_RAMPA=4)
// Ramp scenario runs only when RAMPA_SOFT_EN is defined.

module tb_driver_motor_pwm;

  localparam int P  = 10;
  localparam int TM = 3;

`ifdef RAMPA_SOFT_EN
  localparam logic [1:0] INI_DIR = 2'b11;
`else
  localparam logic [1:0] INI_DIR = 2'b10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dirA, dirB;
  logic [11:0] dcA, dcB;
  logic        in1_A, in2_A, en_A, in1_B, in2_B, en_B;
  logic        sfarsit_perioada, timp_mort_A, timp_mort_B;

  int          vectors = 0;
  int          miscompares = 0;
  int          ph = 0;
  logic [8:0]  sb[$];
  logic [8:0]  exp_v;

  wire [8:0] obs_v = {in1_A, in2_A, en_A, timp_mort_A,
                      in1_B, in2_B, en_B, timp_mort_B, sfarsit_perioada};

  driver_motor_pwm #(.PERIOADA(P), .TIMP_MORT(TM), .PAS_RAMPA(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .directie_driverA  (dirA),
    .directie_driverB  (dirB),
    .factor_dc_driverA (dcA),
    .factor_dc_driverB (dcB),
    .in1_A             (in1_A),
    .in2_A             (in2_A),
    .en_A              (en_A),
    .in1_B             (in1_B),
    .in2_B             (in2_B),
    .en_B              (en_B),
    .sfarsit_perioada  (sfarsit_perioada),
    .timp_mort_A       (timp_mort_A),
    .timp_mort_B       (timp_mort_B)
  );

  always #5 clk = ~clk;

  // ph tracks the counter value of the cycle we are in after each tick
  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % P;
  endtask

  function automatic logic [3:0] canal(input logic [1:0] d, input int duty, input int prev, input bit mort);
    logic pwm;
    pwm = (prev < duty);
    if (mort) return 4'b0001;
    case (d)
      2'b10:   return {2'b10, pwm, 1'b0};
      2'b01:   return {2'b01, pwm, 1'b0};
      2'b00:   return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  // Expected outputs for the next n samples: new settings apply after the next counter==P-1 cycle
  task automatic plan(input int n,
                      input logic [1:0] oad, input int oac, input logic [1:0] nad, input int nac,
                      input logic [1:0] obd, input int obc, input logic [1:0] nbd, input int nbc,
                      input bit inv_a);
    int l, prev;
    bit nou, mort, sf;
    l = (ph == P-1) ? 0 : P-1-ph;
    for (int j = 0; j < n; j++) begin
      prev = (ph + j) % P;
      nou  = (j > l);
      mort = inv_a && nou && (j <= l + TM);
      sf   = (((ph + j + 1) % P) == P-1);
      sb.push_back({canal(nou ? nad : oad, nou ? nac : oac, prev, mort),
                    canal(nou ? nbd : obd, nou ? nbc : obc, prev, 1'b0), sf});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    dirA = INI_DIR; dcA = 12'd6;
    dirB = INI_DIR; dcB = 12'd3;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs_v !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_hold got=%b exp=%b", obs_v, 9'b0);
    end
    rst_n = 1'b1;
    ph = 0;
    plan(30, 2'b11, 0, INI_DIR, 6, 2'b11, 0, INI_DIR, 3, 1'b0);
    repeat (30) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_pwm t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_duty_limits();
    dcA = 12'h998;
    plan(20, 2'b10, 6, 2'b10, 'h998, 2'b10, 3, 2'b10, 3, 1'b0);
    repeat (20) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL duty_full t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
    dcA = 12'd0;
    plan(20, 2'b10, 'h998, 2'b10, 0, 2'b10, 3, 2'b10, 3, 1'b0);
    repeat (20) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL duty_zero t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_mid_period();
    while (ph != 1) tick();
    dirA = 2'b01; dcA = 12'd7; dirB = 2'b00;
    plan(12, 2'b10, 0, 2'b10, 0, 2'b10, 3, 2'b10, 3, 1'b0);
    for (int j = 0; j < 12; j++) begin
      tick();
      if (j == 2) begin
        dirA = 2'b10; dcA = 12'd0; dirB = 2'b10;
      end
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL mid_period t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_dead_time();
    dirA = 2'b01; dcA = 12'd5;
    plan(25, 2'b10, 0, 2'b01, 5, 2'b10, 3, 2'b10, 3, 1'b1);
    repeat (25) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL dead_fwd_rev t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
    dirA = 2'b10;
    plan(25, 2'b01, 5, 2'b10, 5, 2'b10, 3, 2'b10, 3, 1'b1);
    repeat (25) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL dead_rev_fwd t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_brake();
    dirA = 2'b00;
    plan(15, 2'b10, 5, 2'b00, 5, 2'b10, 3, 2'b10, 3, 1'b0);
    repeat (15) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL brake t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
    dirA = 2'b01;
    plan(15, 2'b00, 5, 2'b01, 5, 2'b10, 3, 2'b10, 3, 1'b0);
    repeat (15) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL brake_exit t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_dead();
    if (ph == P-1) tick();
    dirA = 2'b10;
    do tick(); while (ph != P-1);
    tick();
    tick();
    vectors++;
    if (obs_v[8:5] !== 4'b0001) begin
      miscompares++;
      $display("FAIL dead_before_reset got=%b exp=%b", obs_v[8:5], 4'b0001);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_v !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_async got=%b exp=%b", obs_v, 9'b0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    ph = 0;
    plan(14, 2'b11, 0, 2'b10, 5, 2'b11, 0, 2'b10, 3, 1'b0);
    repeat (14) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_release t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  endtask

`ifdef RAMPA_SOFT_EN
  task automatic test_ramp();
    int l, prev, k, duty;
    bit nou, sf;
    int rtab[4] = '{4, 8, 9, 9};
    dirA = 2'b10; dcA = 12'd9;
    l = (ph == P-1) ? 0 : P-1-ph;
    for (int j = 0; j < 45; j++) begin
      prev = (ph + j) % P;
      nou  = (j > l);
      k    = nou ? (j - l - 1) / P : 0;
      duty = rtab[(k > 3) ? 3 : k];
      sf   = (((ph + j + 1) % P) == P-1);
      sb.push_back({canal(nou ? 2'b10 : 2'b11, duty, prev, 1'b0), canal(2'b11, 0, prev, 1'b0), sf});
    end
    repeat (45) begin
      tick();
      exp_v = sb.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL ramp t=%0t got=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef RAMPA_SOFT_EN
    test_ramp();
`else
    test_duty_limits();
    test_mid_period();
    test_dead_time();
    test_brake();
    test_reset_dead();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
